// File: rtl/decode_stage_pkg.sv
// Shared decode constants for the D stage: opcode/funct values, forwarding
// select encodings and the decoded immediate/destination kinds.
package decode_stage_pkg;

    localparam logic [31:0] DEF_NOP_INS  = 32'h0000_0000;
    localparam logic [4:0]  DEF_LINK_REG = 5'd31;
    localparam logic [31:0] DEF_LINK_OFS = 32'd8;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [1:0] {EXT_NONE, EXT_SIGN, EXT_ZERO, EXT_LUI} ext_kind_t;
    typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_LINK} dst_kind_t;

    // Encoding 3 is reserved and falls back to the register file value.
    function automatic logic [31:0] fwd_select(input logic [1:0] sel,
                                               input logic [31:0] grf,
                                               input logic [31:0] e_val,
                                               input logic [31:0] m_val);
        logic [31:0] r;
        case (sel)
            FWD_E:   r = e_val;
            FWD_M:   r = m_val;
            default: r = grf;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_d_cmp.sv
// Branch comparator: equality of the forwarded operands gated by branch type.
module d_cmp
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_beq,
    input  logic        is_bne,
    output logic        taken
);

    logic equal;

    assign equal = (a == b);
    assign taken = (is_beq & equal) | (is_bne & ~equal);

endmodule

// File: rtl/decode_stage.sv
// MIPS D stage: decode, operand forwarding, branch/jump resolution and the
// D/E pipeline register (bubble on stall).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INS  = DEF_NOP_INS,
    parameter logic [4:0]  LINK_REG = DEF_LINK_REG,
    parameter logic [31:0] LINK_OFS = DEF_LINK_OFS
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_PC,
    input  logic [31:0] D_PC,
    input  logic [31:0] D_Ins,
    input  logic        D_Stall,
    output logic [4:0]  D_RA1,
    output logic [4:0]  D_RA2,
    input  logic [31:0] D_RD1,
    input  logic [31:0] D_RD2,
    input  logic [1:0]  D_FwdSel1,
    input  logic [1:0]  D_FwdSel2,
    input  logic [31:0] E_FwdData,
    input  logic [31:0] M_FwdData,
    output logic [31:0] NPC,
    output logic [31:0] E_PC,
    output logic [31:0] E_Ins,
    output logic [31:0] E_RS,
    output logic [31:0] E_RT,
    output logic [31:0] E_EXT,
    output logic [4:0]  E_A3,
    output logic [31:0] E_Link
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [31:0] f_rs;
    logic [31:0] f_rt;
    logic [31:0] ext;
    logic [31:0] imm_sext;
    logic [4:0]  a3;
    logic        is_beq;
    logic        is_bne;
    logic        is_jal;
    logic        is_jr;
    logic        br_taken;
    ext_kind_t   ext_kind;
    dst_kind_t   dst_kind;

    assign opcode = D_Ins[31:26];
    assign funct  = D_Ins[5:0];
    assign rt     = D_Ins[20:16];
    assign rd     = D_Ins[15:11];
    assign imm16  = D_Ins[15:0];
    assign D_RA1  = D_Ins[25:21];
    assign D_RA2  = D_Ins[20:16];

    assign f_rs = fwd_select(D_FwdSel1, D_RD1, E_FwdData, M_FwdData);
    assign f_rt = fwd_select(D_FwdSel2, D_RD2, E_FwdData, M_FwdData);

    // Anything not listed decodes as a nop: no immediate, no destination.
    always_comb begin
        ext_kind = EXT_NONE;
        dst_kind = DST_NONE;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_jal   = 1'b0;
        is_jr    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU,
                    FN_MFHI, FN_MFLO: dst_kind = DST_RD;
                    FN_JR:            is_jr = 1'b1;
                    default:          dst_kind = DST_NONE;
                endcase
            end
            OP_JAL:  begin is_jal = 1'b1; dst_kind = DST_LINK; end
            OP_BEQ:  begin is_beq = 1'b1; ext_kind = EXT_SIGN; end
            OP_BNE:  begin is_bne = 1'b1; ext_kind = EXT_SIGN; end
            OP_ADDI, OP_LB, OP_LH, OP_LW: begin
                ext_kind = EXT_SIGN;
                dst_kind = DST_RT;
            end
            OP_ANDI, OP_ORI: begin ext_kind = EXT_ZERO; dst_kind = DST_RT; end
            OP_LUI:  begin ext_kind = EXT_LUI;  dst_kind = DST_RT; end
            OP_SB, OP_SH, OP_SW: ext_kind = EXT_SIGN;
            default: ext_kind = EXT_NONE;
        endcase
    end

    assign imm_sext = {{16{imm16[15]}}, imm16};

    always_comb begin
        case (ext_kind)
            EXT_SIGN: ext = imm_sext;
            EXT_ZERO: ext = {16'h0000, imm16};
            EXT_LUI:  ext = {imm16, 16'h0000};
            default:  ext = 32'h0000_0000;
        endcase
        case (dst_kind)
            DST_RD:   a3 = rd;
            DST_RT:   a3 = rt;
            DST_LINK: a3 = LINK_REG;
            default:  a3 = 5'd0;
        endcase
    end

    d_cmp u_cmp (
        .a      (f_rs),
        .b      (f_rt),
        .is_beq (is_beq),
        .is_bne (is_bne),
        .taken  (br_taken)
    );

    // NPC ignores D_Stall; fetch decides whether to take it.
    always_comb begin
        if (br_taken)
            NPC = D_PC + 32'd4 + {imm_sext[29:0], 2'b00};
        else if (is_jal)
            NPC = {D_PC[31:28], D_Ins[25:0], 2'b00};
        else if (is_jr)
            NPC = f_rs;
        else
            NPC = F_PC + 32'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || D_Stall) begin
            E_PC   <= 32'h0000_0000;
            E_Ins  <= NOP_INS;
            E_RS   <= 32'h0000_0000;
            E_RT   <= 32'h0000_0000;
            E_EXT  <= 32'h0000_0000;
            E_A3   <= 5'd0;
            E_Link <= 32'h0000_0000;
        end else begin
            E_PC   <= D_PC;
            E_Ins  <= D_Ins;
            E_RS   <= f_rs;
            E_RT   <= f_rt;
            E_EXT  <= ext;
            E_A3   <= a3;
            E_Link <= D_PC + LINK_OFS;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// instructions compared against an arithmetic reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] F_PC, D_PC, D_Ins, D_RD1, D_RD2, E_FwdData, M_FwdData;
    logic        D_Stall;
    logic [1:0]  D_FwdSel1, D_FwdSel2;
    logic [4:0]  D_RA1, D_RA2, E_A3;
    logic [31:0] NPC, E_PC, E_Ins, E_RS, E_RT, E_EXT, E_Link;

    int checkCount = 0;
    int passCount  = 0;

    decode_stage dut (
        .clk(clk), .reset(reset), .F_PC(F_PC), .D_PC(D_PC), .D_Ins(D_Ins),
        .D_Stall(D_Stall), .D_RA1(D_RA1), .D_RA2(D_RA2), .D_RD1(D_RD1),
        .D_RD2(D_RD2), .D_FwdSel1(D_FwdSel1), .D_FwdSel2(D_FwdSel2),
        .E_FwdData(E_FwdData), .M_FwdData(M_FwdData), .NPC(NPC),
        .E_PC(E_PC), .E_Ins(E_Ins), .E_RS(E_RS), .E_RT(E_RT),
        .E_EXT(E_EXT), .E_A3(E_A3), .E_Link(E_Link)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] fpc,
                                 input logic [31:0] ins, input logic [31:0] rd1,
                                 input logic [31:0] rd2, input logic [1:0] s1,
                                 input logic [1:0] s2, input logic [31:0] ed,
                                 input logic [31:0] md, input logic stall);
        D_PC = pc; F_PC = fpc; D_Ins = ins; D_RD1 = rd1; D_RD2 = rd2;
        D_FwdSel1 = s1; D_FwdSel2 = s2; E_FwdData = ed; M_FwdData = md;
        D_Stall = stall;
    endtask

    // Reference model built from the instruction-set rules using plain integers.
    function automatic logic [31:0] modelFwd(input logic [1:0] sel, input logic [31:0] grf,
                                             input logic [31:0] e, input logic [31:0] m);
        if (sel == 2'd1) return e;
        if (sel == 2'd2) return m;
        return grf;
    endfunction

    function automatic int signed immValue(input logic [31:0] ins);
        shortint s;
        s = ins[15:0];
        return int'(s);
    endfunction

    function automatic logic [31:0] modelExt(input logic [31:0] ins);
        int unsigned op = ins[31:26];
        int unsigned uimm = ins[15:0];
        if (op inside {8, 32, 33, 35, 40, 41, 43, 4, 5}) return 32'(immValue(ins));
        if (op inside {12, 13}) return uimm;
        if (op == 15) return uimm * 65536;
        return 0;
    endfunction

    function automatic logic [31:0] modelA3(input logic [31:0] ins);
        int unsigned op = ins[31:26];
        int unsigned fn = ins[5:0];
        if (op == 0 && fn inside {0, 2, 3, 4, 6, 7, 16, 18, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43})
            return 32'(ins[15:11]);
        if (op inside {8, 12, 13, 15, 32, 33, 35}) return 32'(ins[20:16]);
        if (op == 3) return 31;
        return 0;
    endfunction

    function automatic logic [31:0] modelNpc(input logic [31:0] pc, input logic [31:0] fpc,
                                             input logic [31:0] ins, input logic [31:0] rs,
                                             input logic [31:0] rtv);
        int unsigned op = ins[31:26];
        int unsigned fn = ins[5:0];
        int unsigned target = ins[25:0];
        if ((op == 4 && rs == rtv) || (op == 5 && rs != rtv))
            return 32'(pc + 4 + immValue(ins) * 4);
        if (op == 3) return (pc & 32'hF000_0000) | 32'(target * 4);
        if (op == 0 && fn == 8) return rs;
        return 32'(fpc + 4);
    endfunction

    // Checks NPC now, clocks once, then checks every E output against the model.
    task automatic runCycle(input string tag);
        logic [31:0] rs, rtv, xPC, xIns, xRS, xRT, xEXT, xA3, xLink;
        #1;
        rs  = modelFwd(D_FwdSel1, D_RD1, E_FwdData, M_FwdData);
        rtv = modelFwd(D_FwdSel2, D_RD2, E_FwdData, M_FwdData);
        checkOutput({tag, ".NPC"}, NPC, modelNpc(D_PC, F_PC, D_Ins, rs, rtv));
        if (D_Stall) begin
            xPC = 0; xIns = 0; xRS = 0; xRT = 0; xEXT = 0; xA3 = 0; xLink = 0;
        end else begin
            xPC = D_PC; xIns = D_Ins; xRS = rs; xRT = rtv;
            xEXT = modelExt(D_Ins); xA3 = modelA3(D_Ins); xLink = D_PC + 8;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".E_PC"}, E_PC, xPC);
        checkOutput({tag, ".E_Ins"}, E_Ins, xIns);
        checkOutput({tag, ".E_RS"}, E_RS, xRS);
        checkOutput({tag, ".E_RT"}, E_RT, xRT);
        checkOutput({tag, ".E_EXT"}, E_EXT, xEXT);
        checkOutput({tag, ".E_A3"}, {27'd0, E_A3}, xA3);
        checkOutput({tag, ".E_Link"}, E_Link, xLink);
    endtask

    initial begin
        logic [5:0] ops [15];
        logic [5:0] fns [8];
        logic [31:0] ins;
        logic [31:0] rd1;
        ops = '{6'h00, 6'h00, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d,
                6'h0f, 6'h20, 6'h21, 6'h23, 6'h28, 6'h2b, 6'h3f};
        fns = '{6'h20, 6'h08, 6'h10, 6'h12, 6'h18, 6'h11, 6'h2a, 6'h01};

        reset = 1'b1;
        applyStimulus(32'h3000, 32'h3004, 32'h3403_FFFF, 0, 0, 0, 0, 0, 0, 1'b0);
        #2;
        checkOutput("reset.E_Ins", E_Ins, 32'h0);
        checkOutput("reset.E_A3", {27'd0, E_A3}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("load.E_A3", {27'd0, E_A3}, 32'd3);

        // Async reset between edges, then released before the next edge.
        #2 reset = 1'b1;
        #1;
        checkOutput("async.E_Ins", E_Ins, 32'h0);
        checkOutput("async.E_A3", {27'd0, E_A3}, 32'h0);
        #1 reset = 1'b0;
        #1;
        checkOutput("held.E_EXT", E_EXT, 32'h0);
        @(posedge clk);
        #1;

        applyStimulus(32'h3000, 32'h3004, 32'h1022_0004, 5, 5, 0, 0, 9, 9, 1'b0);
        #1 checkOutput("beq.taken", NPC, 32'h3014);
        D_RD2 = 6;
        #1 checkOutput("beq.fall", NPC, 32'h3008);
        runCycle("beq");

        applyStimulus(32'h3008, 32'h300C, 32'h0C00_0C03, 1, 2, 0, 0, 0, 0, 1'b0);
        #1 checkOutput("jal.NPC", NPC, 32'h0000_300C);
        runCycle("jal");
        checkOutput("jal.A3", {27'd0, E_A3}, 32'd31);
        checkOutput("jal.Link", E_Link, 32'h3010);

        applyStimulus(32'h3010, 32'h3014, 32'h03E0_0008, 32'h1234_5678, 0, 2'd2, 0, 7, 32'h4000, 1'b0);
        #1 checkOutput("jr.NPC", NPC, 32'h4000);
        runCycle("jr");

        applyStimulus(32'h3014, 32'h3018, 32'h3403_FFFF, 0, 0, 0, 0, 0, 0, 1'b1);
        runCycle("stall");
        checkOutput("stall.Ins", E_Ins, 32'h0);
        D_Stall = 1'b0;
        runCycle("unstall");
        checkOutput("unstall.EXT", E_EXT, 32'h0000_FFFF);
        checkOutput("unstall.A3", {27'd0, E_A3}, 32'd3);

        applyStimulus(32'h3018, 32'h301C, 32'h3C04_8000, 0, 0, 0, 0, 0, 0, 1'b0);
        runCycle("lui");
        checkOutput("lui.EXT", E_EXT, 32'h8000_0000);
        applyStimulus(32'h301C, 32'h3020, 32'h2005_FFFF, 0, 0, 0, 0, 0, 0, 1'b0);
        runCycle("addi");
        checkOutput("addi.EXT", E_EXT, 32'hFFFF_FFFF);
        applyStimulus(32'h3020, 32'h3024, 32'hAC41_0000, 0, 0, 0, 0, 0, 0, 1'b0);
        runCycle("sw");
        checkOutput("sw.A3", {27'd0, E_A3}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 14)];
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 7)];
            rd1 = $urandom;
            applyStimulus($urandom, $urandom, ins, rd1,
                          ($urandom_range(0, 1) == 1) ? rd1 : $urandom,
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          $urandom, $urandom, $urandom_range(0, 4) == 0);
            runCycle("rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
